// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 key event controller: the scan-code
// prefix bytes, the decoder state encoding and the key event record that
// travels through the event FIFO.
//
// Configuration macro: PS2_EXT_KEY_EN
//   defined   -> extended (E0-prefixed) keys are decoded; the event record
//                carries an ext bit and the decoder has S_EXT / S_EXT_BRK.
//   undefined -> E0 bytes are ignored; the event record is {code, rel} only.
package ps2_kbd_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

`ifdef PS2_EXT_KEY_EN
  typedef enum logic [1:0] {
    S_MAKE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // The release flag is named rel because "release" is a reserved word.
  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } key_event_t;
`else
  typedef enum logic [0:0] {
    S_MAKE = 1'b0,
    S_BRK  = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
  } key_event_t;
`endif

  localparam int EVENT_W = $bits(key_event_t);

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo
// First-word-fall-through FIFO for decoded key events. The head entry is
// visible on o_dout whenever the FIFO is not empty, and o_dout reads as all
// zeros when it is empty.
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   i_push     : write i_din (ignored when full unless a pop happens too)
//   i_pop      : remove the head entry (ignored when empty)
//   i_din      : entry to write
//   o_dout     : head entry, zero when empty
//   o_full     : FIFO holds DEPTH entries
//   o_empty    : FIFO holds no entries
//   o_count    : occupancy, 0..DEPTH
//
// DEPTH must be a power of two so that the pointers wrap by overflowing.
module key_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wrEn;
  logic             w_rdEn;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head is being removed.
  assign w_rdEn = i_pop & ~w_empty;
  assign w_wrEn = i_push & (~w_full | w_rdEn);

  // Storage has no reset; stale entries are never visible because the
  // output is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdEn) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrEn, w_rdEn})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Turns the stream of PS/2 scan bytes into buffered key events. A small
// decoder FSM absorbs the F0 (break) and E0 (extended) prefixes and pushes
// one {code, release, ext} event per non-prefix byte into a FWFT FIFO.
//
// Ports:
//   clk, reset       : system clock, asynchronous active-high reset
//   i_rx_done_tick   : one-cycle strobe, i_dout holds a valid scan byte
//   i_dout           : received scan byte
//   i_pop            : consumer removes the head event
//   i_clr_ovf        : clear the sticky overflow flag
//   o_ev_valid       : at least one event is buffered
//   o_ev_code        : head event key code (0 when empty)
//   o_ev_release     : head event is a break (0 when empty)
//   o_ev_ext         : head event is an extended key (0 when empty)
//   o_ev_count       : FIFO occupancy, 0..FIFO_DEPTH
//   o_overflow       : sticky, an event was dropped because the FIFO was full
//
// Configuration macro: PS2_EXT_KEY_EN enables extended-key decoding. Without
// it E0 bytes are discarded and o_ev_ext is tied to 0.
module ps2_key_event_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_rx_done_tick,
  input  logic [7:0]                    i_dout,
  input  logic                          i_pop,
  input  logic                          i_clr_ovf,
  output logic                          o_ev_valid,
  output logic [7:0]                    o_ev_code,
  output logic                          o_ev_release,
  output logic                          o_ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   o_ev_count,
  output logic                          o_overflow
);

  state_t     r_state;
  state_t     w_stateNext;
  logic       w_push;
  key_event_t w_pushEvent;
  key_event_t w_headEvent;
  logic       w_full;
  logic       w_empty;
  logic       w_drop;
  logic       r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_MAKE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Prefix bytes only move the FSM; any other byte completes an event whose
  // flags come from the state it arrives in, and the FSM returns to S_MAKE.
  always_comb begin
    w_stateNext      = r_state;
    w_push           = 1'b0;
    w_pushEvent      = '0;
    w_pushEvent.code = i_dout;
    if (i_rx_done_tick) begin
      case (r_state)
        S_MAKE: begin
          if (i_dout == BREAK_CODE) begin
            w_stateNext = S_BRK;
          end else if (i_dout == EXT_CODE) begin
`ifdef PS2_EXT_KEY_EN
            w_stateNext = S_EXT;
`else
            w_stateNext = S_MAKE;
`endif
          end else begin
            w_push = 1'b1;
          end
        end
        S_BRK: begin
          if (i_dout == BREAK_CODE) begin
            w_stateNext = S_BRK;
          end else if (i_dout == EXT_CODE) begin
`ifdef PS2_EXT_KEY_EN
            w_stateNext = S_EXT_BRK;
`else
            w_stateNext = S_BRK;
`endif
          end else begin
            w_push          = 1'b1;
            w_pushEvent.rel = 1'b1;
            w_stateNext     = S_MAKE;
          end
        end
`ifdef PS2_EXT_KEY_EN
        S_EXT: begin
          if (i_dout == BREAK_CODE) begin
            w_stateNext = S_EXT_BRK;
          end else if (i_dout == EXT_CODE) begin
            w_stateNext = S_EXT;
          end else begin
            w_push          = 1'b1;
            w_pushEvent.ext = 1'b1;
            w_stateNext     = S_MAKE;
          end
        end
        S_EXT_BRK: begin
          if ((i_dout == BREAK_CODE) || (i_dout == EXT_CODE)) begin
            w_stateNext = S_EXT_BRK;
          end else begin
            w_push          = 1'b1;
            w_pushEvent.rel = 1'b1;
            w_pushEvent.ext = 1'b1;
            w_stateNext     = S_MAKE;
          end
        end
`endif
        default: w_stateNext = S_MAKE;
      endcase
    end
  end

  key_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (i_pop),
    .i_din   (w_pushEvent),
    .o_dout  (w_headEvent),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_ev_count)
  );

  // A full FIFO with a pop in the same cycle accepts the push, so only a
  // push without a pop is lost. A drop wins over a same-cycle clear.
  assign w_drop = w_push & w_full & ~i_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_ev_valid   = ~w_empty;
  assign o_ev_code    = w_headEvent.code;
  assign o_ev_release = w_headEvent.rel;
`ifdef PS2_EXT_KEY_EN
  assign o_ev_ext     = w_headEvent.ext;
`else
  assign o_ev_ext     = 1'b0;
`endif
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
// Self-checking bench for ps2_key_event_ctrl. A reference model tracks the
// pending break/extended flags and a queue of events; directed scenarios
// use constant expectations and a random phase compares against the model.
// Honours PS2_EXT_KEY_EN in the same way as the design.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PS2_EXT_KEY_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          rxDone;
  logic [7:0]    dout;
  logic          popIn;
  logic          clrOvf;
  logic          evValid;
  logic [7:0]    evCode;
  logic          evRelease;
  logic          evExt;
  logic [CW-1:0] evCount;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  // Model state: queued events as {code, rel, ext}, pending prefix flags.
  logic [9:0] mQ[$];
  bit         mBrk;
  bit         mExt;
  bit         mOvf;

  ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_rx_done_tick (rxDone),
    .i_dout         (dout),
    .i_pop          (popIn),
    .i_clr_ovf      (clrOvf),
    .o_ev_valid     (evValid),
    .o_ev_code      (evCode),
    .o_ev_release   (evRelease),
    .o_ev_ext       (evExt),
    .o_ev_count     (evCount),
    .o_overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mQ.delete();
    mBrk = 1'b0;
    mExt = 1'b0;
    mOvf = 1'b0;
  endtask

  function automatic logic [9:0] mHead();
    if (mQ.size() == 0) return 10'd0;
    return mQ[0];
  endfunction

  // Drive one cycle of inputs, let the edge pass, then advance the model.
  task automatic applyStimulus(input bit rx, input logic [7:0] b,
                               input bit pop, input bit clr);
    bit         popEff;
    bit         pushReq;
    bit         drop;
    logic [9:0] ev;
    rxDone = rx;
    dout   = b;
    popIn  = pop;
    clrOvf = clr;
    @(posedge clk);
    #1;
    rxDone = 1'b0;
    dout   = 8'h00;
    popIn  = 1'b0;
    clrOvf = 1'b0;
    popEff  = pop && (mQ.size() > 0);
    pushReq = 1'b0;
    ev      = 10'd0;
    if (rx) begin
      if (b == 8'hF0) begin
        mBrk = 1'b1;
      end else if (b == 8'hE0) begin
        if (EXT_EN) mExt = 1'b1;
      end else begin
        pushReq = 1'b1;
        ev      = {b, mBrk, mExt};
        mBrk    = 1'b0;
        mExt    = 1'b0;
      end
    end
    drop = pushReq && (mQ.size() == DEPTH) && !popEff;
    if (popEff) void'(mQ.pop_front());
    if (pushReq && !drop) mQ.push_back(ev);
    if (drop) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic popOne();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    modelReset();
    #2;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    modelReset();
    #3;
    total += 6;
    if (evValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", evValid); end
    if (evCode !== 8'h00) begin bad++; $display("[TB] FAIL reset_code: got %h want 00", evCode); end
    if (evRelease !== 1'b0) begin bad++; $display("[TB] FAIL reset_release: got %b want 0", evRelease); end
    if (evExt !== 1'b0) begin bad++; $display("[TB] FAIL reset_ext: got %b want 0", evExt); end
    if (evCount !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", evCount); end
    if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if (evCount !== '0) begin bad++; $display("[TB] FAIL post_reset_count: got %0d want 0", evCount); end
  endtask

  task automatic test_make_break();
    sendByte(8'h1C);
    sendByte(8'hF0);
    sendByte(8'h1C);
    total += 4;
    if (evCount !== CW'(2)) begin bad++; $display("[TB] FAIL mb_count: got %0d want 2", evCount); end
    if (evValid !== 1'b1) begin bad++; $display("[TB] FAIL mb_valid: got %b want 1", evValid); end
    if ({evCode, evRelease, evExt} !== {8'h1C, 1'b0, 1'b0})
      begin bad++; $display("[TB] FAIL mb_first: got %h/%b/%b want 1c/0/0", evCode, evRelease, evExt); end
    popOne();
    if ({evCode, evRelease, evExt} !== {8'h1C, 1'b1, 1'b0})
      begin bad++; $display("[TB] FAIL mb_second: got %h/%b/%b want 1c/1/0", evCode, evRelease, evExt); end
    popOne();
    total += 2;
    if (evValid !== 1'b0) begin bad++; $display("[TB] FAIL mb_drained_valid: got %b want 0", evValid); end
    if ({evCode, evRelease, evExt} !== 10'd0)
      begin bad++; $display("[TB] FAIL mb_empty_head: got %h/%b/%b want 00/0/0", evCode, evRelease, evExt); end
  endtask

  task automatic test_extended();
    sendByte(8'hE0);
    sendByte(8'h75);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h75);
    total += 3;
    if (evCount !== CW'(2)) begin bad++; $display("[TB] FAIL ext_count: got %0d want 2", evCount); end
    if ({evCode, evRelease, evExt} !== {8'h75, 1'b0, EXT_EN})
      begin bad++; $display("[TB] FAIL ext_first: got %h/%b/%b want 75/0/%b", evCode, evRelease, evExt, EXT_EN); end
    popOne();
    if ({evCode, evRelease, evExt} !== {8'h75, 1'b1, EXT_EN})
      begin bad++; $display("[TB] FAIL ext_second: got %h/%b/%b want 75/1/%b", evCode, evRelease, evExt, EXT_EN); end
    popOne();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) sendByte(8'h15 + 8'(i));
    total += 3;
    if (evCount !== CW'(DEPTH)) begin bad++; $display("[TB] FAIL ovf_count: got %0d want %0d", evCount, DEPTH); end
    if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    if (evCode !== 8'h15) begin bad++; $display("[TB] FAIL ovf_head: got %h want 15", evCode); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (evCode !== 8'h15 + 8'(i))
        begin bad++; $display("[TB] FAIL ovf_pop%0d: got %h want %h", i, evCode, 8'h15 + 8'(i)); end
      popOne();
    end
    total += 2;
    if (evValid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_drained: got %b want 0", evValid); end
    if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) sendByte(8'h31 + 8'(i));
    applyStimulus(1'b1, 8'h2A, 1'b1, 1'b0);
    total += 3;
    if (evCount !== CW'(DEPTH)) begin bad++; $display("[TB] FAIL fpp_count: got %0d want %0d", evCount, DEPTH); end
    if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL fpp_ovf: got %b want 0", overflow); end
    if (evCode !== 8'h32) begin bad++; $display("[TB] FAIL fpp_head: got %h want 32", evCode); end
    for (int i = 0; i < 3; i++) popOne();
    total++;
    if (evCode !== 8'h2A) begin bad++; $display("[TB] FAIL fpp_last: got %h want 2a", evCode); end
    popOne();
    // Drop and clear in the same cycle: the drop must win.
    for (int i = 0; i < 4; i++) sendByte(8'h41 + 8'(i));
    applyStimulus(1'b1, 8'h4F, 1'b0, 1'b1);
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL set_wins: got %b want 1", overflow); end
    if (evCode !== 8'h41) begin bad++; $display("[TB] FAIL drop_keeps_head: got %h want 41", evCode); end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) popOne();
  endtask

  task automatic test_pop_empty();
    popOne();
    popOne();
    total += 2;
    if (evCount !== '0) begin bad++; $display("[TB] FAIL pop_empty_count: got %0d want 0", evCount); end
    if (evValid !== 1'b0) begin bad++; $display("[TB] FAIL pop_empty_valid: got %b want 0", evValid); end
  endtask

  task automatic test_reset_mid();
    sendByte(8'hF0);
    pulseReset();
    sendByte(8'h1C);
    total += 2;
    if (evCount !== CW'(1)) begin bad++; $display("[TB] FAIL rmid_count: got %0d want 1", evCount); end
    if ({evCode, evRelease, evExt} !== {8'h1C, 1'b0, 1'b0})
      begin bad++; $display("[TB] FAIL rmid_brk: got %h/%b/%b want 1c/0/0", evCode, evRelease, evExt); end
    popOne();
    sendByte(8'hE0);
    pulseReset();
    sendByte(8'h75);
    total++;
    if ({evCode, evRelease, evExt} !== {8'h75, 1'b0, 1'b0})
      begin bad++; $display("[TB] FAIL rmid_ext: got %h/%b/%b want 75/0/0", evCode, evRelease, evExt); end
    popOne();
  endtask

  task automatic test_random();
    logic [9:0] h;
    for (int n = 0; n < 800; n++) begin
      bit         rx;
      bit         pop;
      bit         clr;
      int         sel;
      logic [7:0] b;
      rx  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 2) b = 8'hF0;
      else if (sel < 3) b = 8'hE0;
      else b = 8'($urandom_range(1, 8'hDF));
      pop = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(rx, b, pop, clr);
      h = mHead();
      total += 6;
      if (evValid !== (mQ.size() != 0))
        begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", n, evValid, mQ.size() != 0); end
      if (evCount !== CW'(mQ.size()))
        begin bad++; $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", n, evCount, mQ.size()); end
      if (evCode !== h[9:2])
        begin bad++; $display("[TB] FAIL rnd_code@%0d: got %h want %h", n, evCode, h[9:2]); end
      if (evRelease !== h[1])
        begin bad++; $display("[TB] FAIL rnd_release@%0d: got %b want %b", n, evRelease, h[1]); end
      if (evExt !== h[0])
        begin bad++; $display("[TB] FAIL rnd_ext@%0d: got %b want %b", n, evExt, h[0]); end
      if (overflow !== mOvf)
        begin bad++; $display("[TB] FAIL rnd_ovf@%0d: got %b want %b", n, overflow, mOvf); end
    end
  endtask

  initial begin
    reset  = 1'b1;
    rxDone = 1'b0;
    dout   = 8'h00;
    popIn  = 1'b0;
    clrOvf = 1'b0;
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_full_push_pop();
    test_pop_empty();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, number of key events buffered (power of two, >= 2).
REQ-002 The block SHALL have input clk, 1 bit, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have input rx_done_tick, 1 bit, one-cycle pulse marking a valid received scan byte.
REQ-005 The block SHALL have input dout, 8 bits, scan byte, sampled only when rx_done_tick=1.
REQ-006 The block SHALL have input pop, 1 bit, consumer removes the head event.
REQ-007 The block SHALL have input clr_ovf, 1 bit, clears the overflow flag.
REQ-008 The block SHALL have output ev_valid, 1 bit, FIFO holds at least one event.
REQ-009 The block SHALL have output ev_code, 8 bits, head event key code.
REQ-010 The block SHALL have output ev_release, 1 bit, head event is a key release (break).
REQ-011 The block SHALL have output ev_ext, 1 bit, head event is an extended (E0-prefixed) key.
REQ-012 The block SHALL have output ev_count, clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.
REQ-013 The block SHALL have output overflow, 1 bit, sticky: an event was dropped.

Function
REQ-014 Decoder FSM states SHALL be S_MAKE, S_BRK, S_EXT, S_EXT_BRK; transitions occur only on cycles with rx_done_tick=1.
REQ-015 S_MAKE: F0 -> S_BRK; E0 -> S_EXT; other byte -> push {code, rel=0, ext=0}, stay.
REQ-016 S_EXT: F0 -> S_EXT_BRK; E0 -> stay; other -> push {code, rel=0, ext=1}, -> S_MAKE.
REQ-017 S_BRK: F0 -> stay; E0 -> S_EXT_BRK; other -> push {code, rel=1, ext=0}, -> S_MAKE.
REQ-018 S_EXT_BRK: F0 or E0 -> stay; other -> push {code, rel=1, ext=1}, -> S_MAKE.
REQ-019 Prefix bytes F0/E0 SHALL never be pushed as events.
REQ-020 A push SHALL occur on the clock edge ending the rx_done_tick cycle; ev_valid/ev_count reflect it the following cycle (latency 1).
REQ-021 FIFO SHALL be first-word-fall-through: ev_code/ev_release/ev_ext show the head whenever ev_valid=1; all three are 0 when empty.
REQ-022 pop with ev_valid=1 SHALL remove the head at the next edge; pop when empty SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL be accepted with ev_count unchanged, including when full.
REQ-024 Push when full without pop SHALL drop the new event, leave FIFO contents unchanged, and set overflow.
REQ-025 clr_ovf SHALL clear overflow at the next edge; if a drop occurs in the same cycle, set wins.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; ev_count SHALL range 0..FIFO_DEPTH exactly.

Reset
REQ-027 On reset, the FSM SHALL go to S_MAKE, FIFO empty, ev_count=0, overflow=0, ev_valid=0, ev_code=0, ev_release=0, ev_ext=0.
REQ-028 Reset asserted mid-sequence (after F0 or E0) SHALL discard the pending prefix; no event results from it.

Configuration
REQ-029 Macro PS2_EXT_KEY_EN SHALL compile in extended-code support.
REQ-030 With PS2_EXT_KEY_EN defined, behaviour SHALL be exactly REQ-014..REQ-018.
REQ-031 Without PS2_EXT_KEY_EN, S_EXT and S_EXT_BRK SHALL not exist, E0 SHALL be discarded with no state change, and ev_ext SHALL be constant 0 (not stored in the FIFO).

Structure
REQ-032 Package ps2_kbd_pkg SHALL hold the BREAK_CODE (8'hF0) and EXT_CODE (8'hE0) constants, the FSM state encoding, and the event record layout {code, release, ext}.
REQ-033 The FIFO SHALL be a sub-module key_event_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); the FSM stays in ps2_key_event_ctrl.

Verification
REQ-034 Bytes 1C, F0, 1C -> two events: {1C,rel=0,ext=0} then {1C,rel=1,ext=0}; ev_count=2 after the final byte.
REQ-035 Bytes E0, 75, E0, F0, 75 (EN defined) -> {75,0,1} then {75,1,1}; undefined -> {75,0,0}, {75,1,0}.
REQ-036 Five make codes 15,16,17,18,19 with no pop, FIFO_DEPTH=4 -> ev_count=4, overflow=1, head 15; four pops return 15,16,17,18.
REQ-037 FIFO full, rx_done_tick with 2A and pop in same cycle -> ev_count stays 4, overflow stays 0, 2A appears last.
REQ-038 Byte F0 then reset pulse then byte 1C -> single event {1C,rel=0,ext=0}; clr_ovf=1 with overflow=1 and no drop -> overflow=0 next cycle.
